uart_rx_arbiter: RTL and testbench

Shares the single UART receive queue between `NUM_REQ` processor cores in the multicore system. Each core posts a level read request and receives one byte per grant, chosen by round-robin arbitration. The block owns the `baud_reload` configuration register and supports a flush command that drains the queue. It sits between the cores' memory-mapped I/O decode and the UART receiver's queue interface (`queue_empty`, `num_entries`, `rx_data`, `read_entry`).

---
 rtl/uart_rx_arbiter_pkg.sv | 17 +
 rtl/uart_rx_arbiter_if.sv | 25 ++
 rtl/uart_rx_arbiter_rr_pick.sv | 36 +++
 rtl/uart_rx_arbiter.sv | 104 ++++++++++
 tb/tb_uart_rx_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_arbiter_pkg.sv
// Shared types and constants for the UART receive-queue arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        DONE  = 2'd2,
        FLUSH = 2'd3
    } arb_state_t;

    localparam int BAUD_W = 13;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    localparam logic [BAUD_W-1:0] BAUD_DEFAULT = 13'd5208;

endpackage

// File: rtl/uart_rx_arbiter_if.sv
// Core request/data handshake plus the UART receiver's queue port.
interface uart_rx_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    import uart_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] rvalid;
    logic [DATA_W-1:0]  rdata;
    logic               queue_empty;
    logic [CNT_W-1:0]   num_entries;
    logic [DATA_W-1:0]  rx_data;
    logic               read_entry;

    modport master (
        output req, queue_empty, num_entries, rx_data,
        input  rvalid, rdata, read_entry
    );

    modport slave (
        input  req, queue_empty, num_entries, rx_data,
        output rvalid, rdata, read_entry
    );

endinterface

// File: rtl/uart_rx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               any,
    output logic [PTR_W-1:0]   win
);

    localparam logic [PTR_W:0] SUM_N = (PTR_W+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [PTR_W:0]     sum;

    always_comb begin
        // rot[i] is the request at offset i from rr_ptr
        rot = NUM_REQ'({req, req} >> rr_ptr);
        any = 1'b0;
        sum = '0;
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            end
        end
        if (sum >= SUM_N) begin
            win = PTR_W'(sum - SUM_N);
        end else begin
            win = PTR_W'(sum);
        end
    end

endmodule

// File: rtl/uart_rx_arbiter.sv
// Round-robin sharing of the UART receive queue between NUM_REQ cores,
// with baud reload register and queue flush.
//
// state | meaning
// IDLE  | wait for flush request or a request with data available
// POP   | read_entry high, head byte captured into rdata
// DONE  | rvalid pulse to the winner, advance round-robin pointer
// FLUSH | pop every cycle until queue_empty is seen
module uart_rx_arbiter #(
    parameter int                             NUM_REQ      = 4,
    parameter logic [uart_arb_pkg::BAUD_W-1:0] BAUD_DEFAULT = uart_arb_pkg::BAUD_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    uart_rx_arbiter_if.slave                 bus,
    input  logic                             cfg_we,
    input  logic [uart_arb_pkg::BAUD_W-1:0]  cfg_wdata,
    input  logic                             flush,
    output logic                             busy,
    output logic [uart_arb_pkg::CNT_W-1:0]   rx_count,
    output logic [uart_arb_pkg::BAUD_W-1:0]  baud_reload
);
    import uart_arb_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   pick_win;
    logic               pick_any;
    logic               flush_pend;
    logic [NUM_REQ-1:0] rvalid_q;
    logic [DATA_W-1:0]  rdata_q;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .win    (pick_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            win        <= '0;
            flush_pend <= 1'b0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            rvalid_q <= '0;
            case (state)
                IDLE: begin
                    if (flush_pend) begin
                        state <= FLUSH;
                    end else if (pick_any && !bus.queue_empty) begin
                        win   <= pick_win;
                        state <= POP;
                    end
                end
                POP: begin
                    rdata_q  <= bus.rx_data;
                    rvalid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                    state    <= DONE;
                end
                DONE: begin
                    rr_ptr <= (win == PTR_W'(NUM_REQ-1)) ? '0 : win + PTR_W'(1);
                    state  <= IDLE;
                end
                FLUSH: begin
                    if (bus.queue_empty) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A new flush pulse wins over the clear so it is never lost
            if (flush) begin
                flush_pend <= 1'b1;
            end else if (state == FLUSH && bus.queue_empty) begin
                flush_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_reload <= BAUD_DEFAULT;
            rx_count    <= '0;
        end else begin
            if (cfg_we) begin
                baud_reload <= cfg_wdata;
            end
            rx_count <= bus.num_entries;
        end
    end

    assign busy           = (state != IDLE);
    assign bus.read_entry = !bus.queue_empty && (state == POP || state == FLUSH);
    assign bus.rvalid     = rvalid_q;
    assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// Directed bench for uart_rx_arbiter; the bench models the UART receive queue.
module tb_uart_rx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [12:0] cfg_wdata;
    logic        flush;
    logic        busy;
    logic [7:0]  rx_count;
    logic [12:0] baud_reload;

    logic [7:0] q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_rx_arbiter_if #(.NUM_REQ(4)) bus ();

    uart_rx_arbiter #(.NUM_REQ(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .cfg_we      (cfg_we),
        .cfg_wdata   (cfg_wdata),
        .flush       (flush),
        .busy        (busy),
        .rx_count    (rx_count),
        .baud_reload (baud_reload)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_q();
        bus.queue_empty = (q.size() == 0);
        bus.num_entries = 8'(q.size());
        bus.rx_data     = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    // One clock: pop the model queue if read_entry was high at the edge
    task automatic tick();
        logic re;
        re = bus.read_entry;
        @(posedge clk);
        if (re && q.size() != 0) void'(q.pop_front());
        #1;
        drive_q();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_flush(input string tag, input int exp_re, input int exp_cyc);
        int n_re;
        int n_cyc;
        n_re  = 0;
        n_cyc = 0;
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            n_cyc++;
            if (bus.read_entry) n_re++;
            tick();
        end
        chk({tag, "_reads"}, n_re, exp_re);
        chk({tag, "_cycles"}, n_cyc, exp_cyc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_wdata = '0;
        flush     = 1'b0;
        bus.req   = '0;
        q         = {8'h41};
        drive_q();
        tick();
        tick();

        // Reset state
        chk("rst_baud",   baud_reload, 13'd5208);
        chk("rst_rvalid", bus.rvalid, 4'b0000);
        chk("rst_rdata",  bus.rdata, 8'h00);
        chk("rst_re",     bus.read_entry, 1'b0);
        chk("rst_busy",   busy, 1'b0);
        chk("rst_count",  rx_count, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("count_1", rx_count, 8'h01);

        // Single core, two grants
        q.push_back(8'h42);
        drive_q();
        bus.req = 4'b0100;
        tick();
        chk("t2_re",     bus.read_entry, 1'b1);
        chk("t2_busy",   busy, 1'b1);
        chk("t2_rv_pop", bus.rvalid, 4'b0000);
        tick();
        chk("t2_rvalid", bus.rvalid, 4'b0100);
        chk("t2_rdata",  bus.rdata, 8'h41);
        chk("t2_re_off", bus.read_entry, 1'b0);
        tick();
        chk("t2_rv_clr", bus.rvalid, 4'b0000);
        tick();
        tick();
        chk("t2_rvalid2", bus.rvalid, 4'b0100);
        chk("t2_rdata2",  bus.rdata, 8'h42);
        bus.req = '0;
        tick();

        // All cores requesting, round robin from pointer 0
        do_reset();
        q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        drive_q();
        bus.req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            tick();
            chk($sformatf("t3_rvalid%0d", k), bus.rvalid, 4'b0001 << (k % 4));
            chk($sformatf("t3_rdata%0d", k), bus.rdata, 8'h10 + k);
            tick();
        end
        bus.req = '0;
        tick();

        // Flush arriving during POP
        q = {8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
        drive_q();
        bus.req = 4'b0001;
        tick();
        chk("t4_re_pop", bus.read_entry, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_rvalid", bus.rvalid, 4'b0001);
        chk("t4_rdata",  bus.rdata, 8'h20);
        bus.req = '0;
        tick();
        chk("t4_idle", busy, 1'b0);
        tick();
        chk("t4_busy", busy, 1'b1);
        run_flush("t4_flush", 4, 5);
        chk("t4_count", rx_count, 8'h00);

        // Baud write during a transfer, then reset mid-POP
        q = {8'h33};
        drive_q();
        bus.req = 4'b0010;
        tick();
        cfg_we    = 1'b1;
        cfg_wdata = 13'h0A2;
        tick();
        cfg_we = 1'b0;
        chk("t5_baud",   baud_reload, 13'h0A2);
        chk("t5_rvalid", bus.rvalid, 4'b0010);
        chk("t5_rdata",  bus.rdata, 8'h33);
        bus.req = '0;
        tick();
        q = {8'h44};
        drive_q();
        bus.req = 4'b0001;
        tick();
        chk("t5_re_pop", bus.read_entry, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_re",   bus.read_entry, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_baud", baud_reload, 13'd5208);
        tick();
        chk("t5_rst_rv", bus.rvalid, 4'b0000);
        bus.req = '0;
        rst_n   = 1'b1;
        q.delete();
        drive_q();
        tick();

        // Request waits on an empty queue
        bus.req = 4'b0010;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.read_entry || bus.rvalid != 4'b0000) n++;
        end
        chk("t6_wait", n, 0);
        q.push_back(8'h55);
        drive_q();
        #1;
        tick();
        chk("t6_re", bus.read_entry, 1'b1);
        tick();
        chk("t6_rvalid", bus.rvalid, 4'b0010);
        chk("t6_rdata",  bus.rdata, 8'h55);
        bus.req = '0;
        tick();

        // cfg_we and flush in the same cycle
        q = {8'h01, 8'h02};
        drive_q();
        cfg_we    = 1'b1;
        cfg_wdata = 13'h123;
        flush     = 1'b1;
        tick();
        cfg_we = 1'b0;
        flush  = 1'b0;
        chk("t7_baud", baud_reload, 13'h123);
        chk("t7_idle", busy, 1'b0);
        tick();
        chk("t7_busy", busy, 1'b1);
        run_flush("t7_flush", 2, 3);
        chk("t7_empty", bus.queue_empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
